// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch control block: controller state
// encoding, display-source codes, the default tick divider and the
// state-to-LED decode.
// ---------------------------------------------------------------------------
package stopwatch_pkg;

  // 50 MHz clock / 100 Hz time base = 10 ms per tick.
  localparam int TICK_DIV_DEFAULT = 500000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  // Display source codes driven on disp_sel.
  localparam logic [1:0] DISP_LIVE   = 2'd0;
  localparam logic [1:0] DISP_FROZEN = 2'd1;
  localparam logic [1:0] DISP_RECALL = 2'd2;

  // One-hot LED pattern: bit 0 IDLE, bit 1 RUN, bit 2 LAP, bit 3 PAUSE.
  function automatic logic [3:0] state_onehot(input state_t s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/stopwatch_key_edge.sv
// ---------------------------------------------------------------------------
// key_edge
// Registered falling-edge detector for one debounced, active-low key.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   i_key_n  in   debounced key level, 0 = pressed
//   o_evt    out  high for the single cycle in which a 1->0 transition is
//                 seen against the registered previous sample
// ---------------------------------------------------------------------------
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_key_n,
  output logic o_evt
);

  logic r_prev;
  logic r_arm;

  // r_arm captures the key level while in reset, so a key already held down
  // when reset is released does not count as a press; the detector arms
  // only once the key has been seen released.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= 1'b1;
      r_arm  <= i_key_n;
    end else begin
      r_prev <= i_key_n;
      if (i_key_n) r_arm <= 1'b1;
    end
  end

  assign o_evt = r_arm & r_prev & ~i_key_n;

endmodule

// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
// Control FSM of a lap stopwatch. Generates the 10 ms tick for an external
// BCD time counter, its clear strobe, lap-memory write/recall addressing and
// the display source select. Time and lap storage live outside this block.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   key_start  in   run/pause key, debounced active-low
//   key_lap    in   lap/recall key, debounced active-low
//   key_clear  in   clear key, debounced active-low
//   tick       out  one-cycle increment strobe to the time counter
//   cnt_clr    out  one-cycle clear strobe to the time counter
//   disp_sel   out  display source: 0 live, 1 frozen, 2 lap recall
//   lap_wr     out  one-cycle write of the live time into slot lap_waddr
//   lap_waddr  out  lap slot written by the next lap_wr
//   lap_raddr  out  lap slot shown while disp_sel = 2
//   lap_count  out  number of valid lap slots (saturates at LAP_DEPTH)
//   state_led  out  one-hot state {PAUSE, LAP, RUN, IDLE}
// ---------------------------------------------------------------------------
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter  int TICK_DIV  = TICK_DIV_DEFAULT,
  parameter  int LAP_DEPTH = 4,
  localparam int LAP_AW    = $clog2(LAP_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_start,
  input  logic              key_lap,
  input  logic              key_clear,
  output logic              tick,
  output logic              cnt_clr,
  output logic [1:0]        disp_sel,
  output logic              lap_wr,
  output logic [LAP_AW-1:0] lap_waddr,
  output logic [LAP_AW-1:0] lap_raddr,
  output logic [LAP_AW:0]   lap_count,
  output logic [3:0]        state_led
);

  localparam int DIV_W = $clog2(TICK_DIV);

  logic w_ev_start, w_ev_lap, w_ev_clr;
  logic w_start, w_lap, w_clr;
  logic w_div_last;
  logic w_recall_ok;
  logic [LAP_AW:0]   w_raddr_inc;
  logic [LAP_AW-1:0] w_recall_addr;

  state_t            r_state;
  logic [3:0]        r_led;
  logic [DIV_W-1:0]  r_div;
  logic              r_tick;
  logic              r_cnt_clr;
  logic              r_lap_wr;
  logic [1:0]        r_disp;
  logic [LAP_AW-1:0] r_waddr;
  logic [LAP_AW-1:0] r_raddr;
  logic [LAP_AW:0]   r_count;

  key_edge u_edge_start (.clk(clk), .reset(reset), .i_key_n(key_start), .o_evt(w_ev_start));
  key_edge u_edge_lap   (.clk(clk), .reset(reset), .i_key_n(key_lap),   .o_evt(w_ev_lap));
  key_edge u_edge_clear (.clk(clk), .reset(reset), .i_key_n(key_clear), .o_evt(w_ev_clr));

  // Priority clear > start > lap; a losing event is dropped even when the
  // winner has no effect in the current state.
  assign w_clr   = w_ev_clr;
  assign w_start = w_ev_start & ~w_ev_clr;
  assign w_lap   = w_ev_lap & ~w_ev_start & ~w_ev_clr;

  assign w_div_last = (r_div == DIV_W'(TICK_DIV - 1));

  // Recall stepping: the first step (display not yet in recall) shows slot 0,
  // later steps walk through the valid slots and wrap at lap_count.
  assign w_recall_ok   = (r_count != '0);
  assign w_raddr_inc   = (LAP_AW+1)'(r_raddr) + (LAP_AW+1)'(1);
  assign w_recall_addr = ((r_disp != DISP_RECALL) || (w_raddr_inc >= r_count))
                         ? '0 : w_raddr_inc[LAP_AW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_led     <= state_onehot(ST_IDLE);
      r_div     <= '0;
      r_tick    <= 1'b0;
      r_cnt_clr <= 1'b1;
      r_lap_wr  <= 1'b0;
      r_disp    <= DISP_LIVE;
      r_waddr   <= '0;
      r_raddr   <= '0;
      r_count   <= '0;
    end else begin
      r_tick    <= 1'b0;
      r_cnt_clr <= 1'b0;
      r_lap_wr  <= 1'b0;

      // Time base runs in RUN and LAP and simply holds elsewhere, so a
      // resume from PAUSE continues with the same phase.
      if (r_state == ST_RUN || r_state == ST_LAP) begin
        if (w_div_last) begin
          r_div  <= '0;
          r_tick <= 1'b1;
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
      end

      // Lap write address and count advance after the strobe, so lap_waddr
      // names the slot being written while lap_wr is high.
      if (r_lap_wr) begin
        r_waddr <= r_waddr + LAP_AW'(1);
        if (r_count != (LAP_AW+1)'(LAP_DEPTH)) r_count <= r_count + (LAP_AW+1)'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (w_clr) begin
            r_cnt_clr <= 1'b1;
          end else if (w_start) begin
            r_state <= ST_RUN;
            r_led   <= state_onehot(ST_RUN);
            r_div   <= '0;
            r_disp  <= DISP_LIVE;
          end else if (w_lap && w_recall_ok) begin
            r_disp  <= DISP_RECALL;
            r_raddr <= w_recall_addr;
          end
        end
        ST_RUN: begin
          if (w_start) begin
            r_state <= ST_PAUSE;
            r_led   <= state_onehot(ST_PAUSE);
          end else if (w_lap) begin
            r_state  <= ST_LAP;
            r_led    <= state_onehot(ST_LAP);
            r_lap_wr <= 1'b1;
            r_disp   <= DISP_FROZEN;
          end
        end
        ST_LAP: begin
          if (w_start) begin
            r_state <= ST_PAUSE;
            r_led   <= state_onehot(ST_PAUSE);
          end else if (w_lap) begin
            r_state  <= ST_RUN;
            r_led    <= state_onehot(ST_RUN);
            r_lap_wr <= 1'b1;
            r_disp   <= DISP_LIVE;
          end
        end
        ST_PAUSE: begin
          if (w_clr) begin
            r_state   <= ST_IDLE;
            r_led     <= state_onehot(ST_IDLE);
            r_cnt_clr <= 1'b1;
            r_count   <= '0;
            r_waddr   <= '0;
            r_raddr   <= '0;
            r_disp    <= DISP_LIVE;
          end else if (w_start) begin
            r_state <= ST_RUN;
            r_led   <= state_onehot(ST_RUN);
            r_disp  <= DISP_LIVE;
            r_raddr <= '0;
          end else if (w_lap && w_recall_ok) begin
            r_disp  <= DISP_RECALL;
            r_raddr <= w_recall_addr;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_led   <= state_onehot(ST_IDLE);
        end
      endcase
    end
  end

  assign tick      = r_tick;
  assign cnt_clr   = r_cnt_clr;
  assign lap_wr    = r_lap_wr;
  assign disp_sel  = r_disp;
  assign lap_waddr = r_waddr;
  assign lap_raddr = r_raddr;
  assign lap_count = r_count;
  assign state_led = r_led;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_start = 1'b1;
  logic       key_lap = 1'b1;
  logic       key_clear = 1'b1;
  logic       tick, cnt_clr, lap_wr;
  logic [1:0] disp_sel;
  logic [1:0] lap_waddr, lap_raddr;
  logic [2:0] lap_count;
  logic [3:0] state_led;

  stopwatch_ctrl #(.TICK_DIV(4), .LAP_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .key_start(key_start), .key_lap(key_lap), .key_clear(key_clear),
    .tick(tick), .cnt_clr(cnt_clr), .disp_sel(disp_sel),
    .lap_wr(lap_wr), .lap_waddr(lap_waddr), .lap_raddr(lap_raddr),
    .lap_count(lap_count), .state_led(state_led)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_seen = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  int n_vec = 0;
  int n_err = 0;

  typedef struct { int cyc; int addr; } wr_t;
  int  q_tick[$];
  int  q_clr[$];
  wr_t q_wr[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Scoreboard monitor: strobes are matched against the expected-cycle queues.
  always @(negedge clk) begin
    if (!rst_seen) begin
      while (q_tick.size() > 0 && q_tick[0] < cyc) chk("tick_missing", -1, q_tick.pop_front());
      while (q_clr.size()  > 0 && q_clr[0]  < cyc) chk("cnt_clr_missing", -1, q_clr.pop_front());
      while (q_wr.size()   > 0 && q_wr[0].cyc < cyc) begin
        wr_t m;
        m = q_wr.pop_front();
        chk("lap_wr_missing", -1, m.cyc);
      end
      if (tick === 1'b1) begin
        if (q_tick.size() == 0) chk("tick_unexpected", cyc, -1);
        else chk("tick_cycle", cyc, q_tick.pop_front());
      end
      if (cnt_clr === 1'b1) begin
        if (q_clr.size() == 0) chk("cnt_clr_unexpected", cyc, -1);
        else chk("cnt_clr_cycle", cyc, q_clr.pop_front());
      end
      if (lap_wr === 1'b1) begin
        if (q_wr.size() == 0) chk("lap_wr_unexpected", cyc, -1);
        else begin
          wr_t e;
          e = q_wr.pop_front();
          chk("lap_wr_cycle", cyc, e.cyc);
          chk("lap_waddr", int'(lap_waddr), e.addr);
        end
      end
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Key(s) go low at negedge c; the event edge is c+1 and its outputs are
  // visible when this task returns.
  task automatic press(input int c, input bit s, input bit l, input bit cl);
    wait_to(c);
    if (s)  key_start = 1'b0;
    if (l)  key_lap   = 1'b0;
    if (cl) key_clear = 1'b0;
    @(negedge clk);
    key_start = 1'b1;
    key_lap   = 1'b1;
    key_clear = 1'b1;
  endtask

  task automatic push_wr(input int c, input int a);
    wr_t w;
    w.cyc  = c;
    w.addr = a;
    q_wr.push_back(w);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tick"},      int'(tick), 0);
    chk({tag, "_cnt_clr"},   int'(cnt_clr), 1);
    chk({tag, "_lap_wr"},    int'(lap_wr), 0);
    chk({tag, "_disp_sel"},  int'(disp_sel), 0);
    chk({tag, "_lap_waddr"}, int'(lap_waddr), 0);
    chk({tag, "_lap_raddr"}, int'(lap_raddr), 0);
    chk({tag, "_lap_count"}, int'(lap_count), 0);
    chk({tag, "_state_led"}, int'(state_led), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b, s, p, r, p2, c, s2, p3, r3;
    int exp_raddr[4];
    exp_raddr = '{0, 1, 2, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;
    b = cyc;

    // Start from IDLE: RUN, tick every 4th cycle from the entry edge
    s = b + 2;
    for (int k = 1; k <= 3; k++) q_tick.push_back(s + 4 * k);
    press(b + 1, 1, 0, 0);
    chk("run_state_led", int'(state_led), 4'b0010);
    chk("run_disp_sel", int'(disp_sel), 0);

    // Pause with the divider at 2, hold 10 cycles, resume: tick after 2 cycles
    p = s + 14;
    press(s + 13, 1, 0, 0);
    chk("pause_state_led", int'(state_led), 4'b1000);
    r = p + 11;
    for (int j = 0; j < 8; j++) q_tick.push_back(r + 2 + 4 * j);
    press(p + 10, 1, 0, 0);
    chk("resume_state_led", int'(state_led), 4'b0010);
    chk("resume_disp_sel", int'(disp_sel), 0);

    // Ten lap presses alternating RUN/LAP; write address wraps
    for (int i = 0; i < 10; i++) begin
      push_wr(r + 3 + 3 * i, i % 4);
      press(r + 2 + 3 * i, 0, 1, 0);
      chk("lap_state_led", int'(state_led), (i % 2 == 0) ? 4'b0100 : 4'b0010);
      chk("lap_disp_sel", int'(disp_sel), (i % 2 == 0) ? 1 : 0);
    end

    p2 = r + 32;
    press(r + 31, 1, 0, 0);
    chk("pause2_state_led", int'(state_led), 4'b1000);
    chk("lap_count_sat", int'(lap_count), 4);
    chk("lap_waddr_after10", int'(lap_waddr), 2);

    // Start and clear together in PAUSE: clear wins, IDLE, one cnt_clr
    c = p2 + 3;
    q_clr.push_back(c);
    press(p2 + 2, 1, 0, 1);
    chk("clear_state_led", int'(state_led), 4'b0001);
    chk("clear_disp_sel", int'(disp_sel), 0);
    chk("clear_lap_count", int'(lap_count), 0);
    chk("clear_lap_waddr", int'(lap_waddr), 0);
    chk("clear_lap_raddr", int'(lap_raddr), 0);

    // Recall with no laps stored is ignored
    press(c + 3, 0, 1, 0);
    chk("empty_recall_disp", int'(disp_sel), 0);
    chk("idle_hold_state_led", int'(state_led), 4'b0001);

    // Three laps, then pause from LAP keeps the frozen display
    s2 = c + 6;
    q_tick.push_back(s2 + 4);
    q_tick.push_back(s2 + 8);
    push_wr(s2 + 2, 0);
    push_wr(s2 + 4, 1);
    push_wr(s2 + 6, 2);
    press(c + 5, 1, 0, 0);
    press(s2 + 1, 0, 1, 0);
    press(s2 + 3, 0, 1, 0);
    press(s2 + 5, 0, 1, 0);
    p3 = s2 + 8;
    press(s2 + 7, 1, 0, 0);
    chk("pause3_state_led", int'(state_led), 4'b1000);
    chk("pause3_disp_sel", int'(disp_sel), 1);
    chk("pause3_lap_count", int'(lap_count), 3);

    // Recall steps through slots 0,1,2,0
    for (int k = 0; k < 4; k++) begin
      press(p3 + 1 + 2 * k, 0, 1, 0);
      chk("recall_disp_sel", int'(disp_sel), 2);
      chk("recall_raddr", int'(lap_raddr), exp_raddr[k]);
    end

    // Resume clears the recall pointer and shows live time
    r3 = p3 + 10;
    q_tick.push_back(r3 + 4);
    q_tick.push_back(r3 + 8);
    press(p3 + 9, 1, 0, 0);
    chk("resume3_state_led", int'(state_led), 4'b0010);
    chk("resume3_disp_sel", int'(disp_sel), 0);
    chk("resume3_raddr", int'(lap_raddr), 0);

    // Clear in RUN has no effect
    press(r3 + 5, 0, 0, 1);
    chk("run_clear_state_led", int'(state_led), 4'b0010);

    // Reset mid-RUN with start held through reset
    wait_to(r3 + 9);
    reset = 1'b1;
    key_start = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrun_reset");
    wait_to(r3 + 12);
    reset = 1'b0;
    wait_to(r3 + 15);
    chk("held_key_state_led", int'(state_led), 4'b0001);
    key_start = 1'b1;
    wait_to(r3 + 18);
    chk("release_state_led", int'(state_led), 4'b0001);
    chk("release_cnt_clr", int'(cnt_clr), 0);

    repeat (2) @(negedge clk);
    chk("tick_queue_left", q_tick.size(), 0);
    chk("cnt_clr_queue_left", q_clr.size(), 0);
    chk("lap_wr_queue_left", q_wr.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
